// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int DATA_BITS           = 8;
  localparam int FRAME_BITS          = 11;
  localparam int DEF_FILTER_LEN      = 8;
  localparam int DEF_TIMEOUT_CYCLES  = 200000;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_glitch_filter.sv
// Synchroniser + stability filter + registered falling-edge pulse for the PS/2 clock.
module ps2_glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          filt_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q;

  // Two-flop synchroniser, idles high like the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Filtered level flips only after the synced level has differed for FILTER_LEN cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filter state and the edge register (one cycle after the filtered level falls).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
      fall_q      <= filt_prev_q & ~filt_q;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/odd parity/stop
// frames and reports good bytes or dropped frames as single-cycle pulses.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e          state_q, state_d;
  logic                kclk_fall;
  logic                kd_sync1_q, kd_sync2_q;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]          keycode_q, keycode_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                to_hit;
  logic                frame_ok;

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (kclk_i),
    .fall_o (kclk_fall)
  );

  // kdata only needs synchronising: it is sampled well inside the clock-low window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kd_sync1_q <= 1'b1;
      kd_sync2_q <= 1'b1;
    end else begin
      kd_sync1_q <= kdata_i;
      kd_sync2_q <= kd_sync1_q;
    end
  end

  // Counter reads k-1 k cycles after an edge; firing at TIMEOUT_CYCLES-2 puts the
  // registered error pulse exactly TIMEOUT_CYCLES cycles after that edge.
  assign to_hit   = (state_q != IDLE) && !kclk_fall &&
                    (to_cnt_q == TW'(TIMEOUT_CYCLES - 2));
  assign frame_ok = kd_sync2_q && odd_parity_ok(shift_q, par_q);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: advance one field per filtered falling edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (kclk_fall && !kd_sync2_q) state_d = DATA;
      DATA:   if (to_hit) state_d = IDLE;
              else if (kclk_fall && bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
      PARITY: if (to_hit) state_d = IDLE;
              else if (kclk_fall) state_d = STOP;
      STOP:   if (to_hit || kclk_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: verdict on the stop edge, or a timeout drop.
  always_comb begin
    valid_d   = 1'b0;
    err_d     = to_hit;
    keycode_d = keycode_q;
    if (state_q == STOP && kclk_fall) begin
      if (frame_ok) begin
        valid_d   = 1'b1;
        keycode_d = shift_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Datapath next state: bit counter, shift register, parity bit, inactivity counter.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q + TW'(1);
    if (state_q == IDLE || kclk_fall || to_hit) to_cnt_d = '0;
    if (state_q == IDLE) bit_cnt_d = '0;
    if (kclk_fall) begin
      if (state_q == DATA) begin
        shift_d[bit_cnt_q] = kd_sync2_q;
        bit_cnt_d          = bit_cnt_q + 3'd1;
      end
      if (state_q == PARITY) par_d = kd_sync2_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      keycode_q <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign keycode_o       = keycode_q;
  assign keycode_valid_o = valid_q;
  assign frame_err_o     = err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: good frames, back-to-back, parity/stop errors,
// clock glitches, timeout and mid-frame reset.
module tb_ps2_frame_rx;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       kclk_i;
  logic       kdata_i;
  logic [7:0] keycode_o;
  logic       keycode_valid_o;
  logic       frame_err_o;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .kclk_i          (kclk_i),
    .kdata_i         (kdata_i),
    .keycode_o       (keycode_o),
    .keycode_valid_o (keycode_valid_o),
    .frame_err_o     (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcnt = 0, ecnt = 0, both_cnt = 0, wide_cnt = 0;
  int v_cyc = 0, e_cyc = 0;
  int last_fall = 0;
  logic prev_v = 1'b0, prev_e = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (keycode_valid_o === 1'b1) begin vcnt <= vcnt + 1; v_cyc <= cyc; end
    if (frame_err_o === 1'b1)     begin ecnt <= ecnt + 1; e_cyc <= cyc; end
    if (keycode_valid_o === 1'b1 && frame_err_o === 1'b1) both_cnt <= both_cnt + 1;
    if ((keycode_valid_o === 1'b1 && prev_v) || (frame_err_o === 1'b1 && prev_e))
      wide_cnt <= wide_cnt + 1;
    prev_v <= (keycode_valid_o === 1'b1);
    prev_e <= (frame_err_o === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(posedge clk_i); #1 kdata_i = b;
    repeat (HALF) @(posedge clk_i);
    #1 kclk_i = 1'b0; last_fall = cyc;
    repeat (HALF) @(posedge clk_i);
    #1 kclk_i = 1'b1;
    if (glitch) begin
      repeat (10) @(posedge clk_i);
      #1 kclk_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 kclk_i = 1'b1;
    end
    repeat (HALF) @(posedge clk_i);
  endtask

  // Sends the first nbits of a frame; glitch_at selects a bit whose high phase gets a glitch.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                            input int nbits, input int glitch_at);
    logic [10:0] fr;
    fr = {stop_b, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_at);
  endtask

  int v0, e0;

  initial begin
    rst_ni = 1'b0; kclk_i = 1'b1; kdata_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_keycode", {24'd0, keycode_o}, 32'h00);
    check("rst_valid", {31'd0, keycode_valid_o}, 32'd0);
    check("rst_err", {31'd0, frame_err_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);

    // Single good frame 0x1C and its latency from the raw stop fall.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    repeat (10) @(posedge clk_i); #1;
    check("f1c_valid_cnt", vcnt - v0, 1);
    check("f1c_err_cnt", ecnt - e0, 0);
    check("f1c_keycode", {24'd0, keycode_o}, 32'h1C);
    check("f1c_latency", v_cyc - last_fall, FL + 4);

    // Back-to-back 0xF0 then 0x1C.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    check("b2b_first_keycode", {24'd0, keycode_o}, 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    repeat (10) @(posedge clk_i); #1;
    check("b2b_second_keycode", {24'd0, keycode_o}, 32'h1C);
    check("b2b_valid_cnt", vcnt - v0, 2);
    check("b2b_err_cnt", ecnt - e0, 0);

    // Bad parity.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    repeat (10) @(posedge clk_i); #1;
    check("par_err_cnt", ecnt - e0, 1);
    check("par_valid_cnt", vcnt - v0, 0);
    check("par_keycode_hold", {24'd0, keycode_o}, 32'h1C);
    check("par_err_latency", e_cyc - last_fall, FL + 4);

    // Bad stop bit.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h5A, 1'b0, 1'b0, 11, -1);
    repeat (10) @(posedge clk_i); #1;
    check("stop_err_cnt", ecnt - e0, 1);
    check("stop_valid_cnt", vcnt - v0, 0);
    check("stop_keycode_hold", {24'd0, keycode_o}, 32'h1C);

    // Glitch in IDLE, then 0x5A with a glitch after data bit 3.
    v0 = vcnt; e0 = ecnt;
    @(posedge clk_i); #1 kclk_i = 1'b0;
    repeat (3) @(posedge clk_i); #1 kclk_i = 1'b1;
    repeat (30) @(posedge clk_i); #1;
    check("idle_glitch_pulses", (vcnt - v0) + (ecnt - e0), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 4);
    repeat (10) @(posedge clk_i); #1;
    check("glitch_keycode", {24'd0, keycode_o}, 32'h5A);
    check("glitch_valid_cnt", vcnt - v0, 1);
    check("glitch_err_cnt", ecnt - e0, 0);

    // Timeout after start + 4 data bits.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h29, 1'b0, 1'b1, 5, -1);
    repeat (TO + 50) @(posedge clk_i); #1;
    check("to_err_cnt", ecnt - e0, 1);
    check("to_latency", e_cyc - last_fall, FL + 3 + TO);
    check("to_valid_cnt", vcnt - v0, 0);
    check("to_keycode_hold", {24'd0, keycode_o}, 32'h5A);
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    repeat (10) @(posedge clk_i); #1;
    check("after_to_keycode", {24'd0, keycode_o}, 32'h29);
    check("after_to_valid_cnt", vcnt - v0, 1);
    check("after_to_err_cnt", ecnt - e0, 0);

    // Reset after 6 data bits.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'hAB, 1'b0, 1'b1, 7, -1);
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("midrst_keycode", {24'd0, keycode_o}, 32'h00);
    check("midrst_valid", {31'd0, keycode_valid_o}, 32'd0);
    check("midrst_err", {31'd0, frame_err_o}, 32'd0);
    repeat (4) @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (TO + 50) @(posedge clk_i); #1;
    check("midrst_no_pulses", (vcnt - v0) + (ecnt - e0), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    repeat (10) @(posedge clk_i); #1;
    check("postrst_keycode", {24'd0, keycode_o}, 32'h1C);
    check("postrst_valid_cnt", vcnt - v0, 1);
    check("postrst_err_cnt", ecnt - e0, 0);

    check("never_both", both_cnt, 0);
    check("pulse_width_one", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
